// File: rtl/btn_event_gen_if.sv
`default_nettype none
// ============================================================================
// btn_event_gen_if : button inputs and event outputs of btn_event_gen
// Rev 1.0
// ============================================================================
interface btn_event_gen_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_i;
    logic [NUM_BTN-1:0] btn_state_o;
    logic               evt_valid_o;
    logic [7:0]         evt_code_o;
    logic [7:0]         evt_cnt_o;

    modport master (
        output btn_i,
        input  btn_state_o,
        input  evt_valid_o,
        input  evt_code_o,
        input  evt_cnt_o
    );

    modport slave (
        input  btn_i,
        output btn_state_o,
        output evt_valid_o,
        output evt_code_o,
        output evt_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/btn_event_gen.sv
`default_nettype none
// ============================================================================
// btn_event_gen : debounces buttons into SHORT/LONG/REPEAT events; BTN_REPEAT_EN builds repeat logic
// Rev 1.0
// ============================================================================
module btn_event_gen #(
    parameter int NUM_BTN      = 2,
    parameter int TICKS_PER_MS = 27000,
    parameter int DEBOUNCE_MS  = 20,
    parameter int LONGPRESS_MS = 1000,
    parameter int REPEAT_MS    = 200
) (
    input  wire            clk27,
    input  wire            reset,
    btn_event_gen_if.slave bus
);

    typedef enum logic [2:0] {
        S_LOCKOUT    = 3'd0,
        S_IDLE       = 3'd1,
        S_PRESS_DB   = 3'd2,
        S_HELD       = 3'd3,
        S_RELEASE_DB = 3'd4
    } btn_state_t;

    localparam int         c_pw         = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [c_pw-1:0] c_presc_max = c_pw'(TICKS_PER_MS - 1);
    localparam logic [4:0]  c_db        = 5'(DEBOUNCE_MS);
    localparam logic [11:0] c_long      = 12'(LONGPRESS_MS);
    // hold_cnt never has to count past the larger of its two thresholds
    localparam logic [11:0] c_hold_max  = 12'((LONGPRESS_MS > REPEAT_MS) ? LONGPRESS_MS : REPEAT_MS);
    localparam logic [1:0]  c_evt_short = 2'b01;
    localparam logic [1:0]  c_evt_long  = 2'b10;
`ifdef BTN_REPEAT_EN
    localparam logic [11:0] c_rep        = 12'(REPEAT_MS);
    localparam logic [1:0]  c_evt_repeat = 2'b11;
`endif

    logic [c_pw-1:0]    r_presc;
    logic               w_tick;
    logic [NUM_BTN-1:0] w_pend;
    logic [1:0]         w_ptype [NUM_BTN];
    logic [NUM_BTN-1:0] w_grant;
    logic [NUM_BTN-1:0] w_btn_state;
    logic               w_found;
    logic [3:0]         w_sel_idx;
    logic [1:0]         w_sel_type;
    logic               r_evt_valid;
    logic [7:0]         r_evt_code;
    logic [7:0]         r_evt_cnt;

    assign w_tick = (r_presc == c_presc_max);

    always_ff @(posedge clk27) begin
        if (reset || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_pw'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_state_t  r_state;
            logic [4:0]  r_db_cnt;
            logic [11:0] r_hold_cnt;
            logic        r_long_flag;
            logic        r_level;
            logic        r_pend;
            logic [1:0]  r_ptype;
            logic        w_pressed;
            logic [4:0]  w_db_nxt;
            logic [11:0] w_hold_nxt;

            assign w_pressed  = ~bus.btn_i[gi];
            assign w_db_nxt   = r_db_cnt + 5'd1;
            assign w_hold_nxt = (r_hold_cnt >= c_hold_max) ? r_hold_cnt : r_hold_cnt + 12'd1;

            assign w_btn_state[gi] = r_level;
            assign w_pend[gi]      = r_pend;
            assign w_ptype[gi]     = r_ptype;

            always_ff @(posedge clk27) begin
                if (reset) begin
                    r_state     <= S_LOCKOUT;
                    r_db_cnt    <= '0;
                    r_hold_cnt  <= '0;
                    r_long_flag <= 1'b0;
                    r_level     <= 1'b0;
                    r_pend      <= 1'b0;
                    r_ptype     <= '0;
                end else begin
                    // A new emission below overrides the arbiter's clear
                    if (w_grant[gi]) begin
                        r_pend <= 1'b0;
                    end
                    case (r_state)
                        S_LOCKOUT: begin
                            if (w_tick) begin
                                if (w_pressed) begin
                                    r_db_cnt <= '0;
                                end else if (w_db_nxt == c_db) begin
                                    r_db_cnt <= '0;
                                    r_state  <= S_IDLE;
                                end else begin
                                    r_db_cnt <= w_db_nxt;
                                end
                            end
                        end
                        S_IDLE: begin
                            if (w_pressed) begin
                                r_db_cnt <= '0;
                                r_state  <= S_PRESS_DB;
                            end
                        end
                        S_PRESS_DB: begin
                            if (w_tick) begin
                                if (!w_pressed) begin
                                    r_state <= S_IDLE;
                                end else if (w_db_nxt == c_db) begin
                                    r_state     <= S_HELD;
                                    r_hold_cnt  <= '0;
                                    r_long_flag <= 1'b0;
                                    r_level     <= 1'b1;
                                end else begin
                                    r_db_cnt <= w_db_nxt;
                                end
                            end
                        end
                        S_HELD: begin
                            if (w_tick) begin
                                if (!w_pressed) begin
                                    r_state  <= S_RELEASE_DB;
                                    r_db_cnt <= '0;
                                end else if (!r_long_flag) begin
                                    if (w_hold_nxt == c_long) begin
                                        r_pend      <= 1'b1;
                                        r_ptype     <= c_evt_long;
                                        r_long_flag <= 1'b1;
                                        r_hold_cnt  <= '0;
                                    end else begin
                                        r_hold_cnt <= w_hold_nxt;
                                    end
                                end
`ifdef BTN_REPEAT_EN
                                else if (w_hold_nxt == c_rep) begin
                                    r_pend     <= 1'b1;
                                    r_ptype    <= c_evt_repeat;
                                    r_hold_cnt <= '0;
                                end else begin
                                    r_hold_cnt <= w_hold_nxt;
                                end
`endif
                            end
                        end
                        S_RELEASE_DB: begin
                            if (w_tick) begin
                                if (w_pressed) begin
                                    r_state <= S_HELD;
                                end else if (w_db_nxt == c_db) begin
                                    r_state  <= S_IDLE;
                                    r_db_cnt <= '0;
                                    r_level  <= 1'b0;
                                    if (!r_long_flag) begin
                                        r_pend  <= 1'b1;
                                        r_ptype <= c_evt_short;
                                    end
                                end else begin
                                    r_db_cnt <= w_db_nxt;
                                end
                            end
                        end
                        default: begin
                            r_state <= S_LOCKOUT;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Lowest index wins: the descending scan leaves the smallest pending index selected
    always_comb begin
        w_found    = 1'b0;
        w_sel_idx  = '0;
        w_sel_type = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_found    = 1'b1;
                w_sel_idx  = 4'(i);
                w_sel_type = w_ptype[i];
            end
        end
    end

    assign w_grant = w_found ? (NUM_BTN'(1) << w_sel_idx) : '0;

    always_ff @(posedge clk27) begin
        if (reset) begin
            r_evt_valid <= 1'b0;
            r_evt_code  <= '0;
            r_evt_cnt   <= '0;
        end else begin
            r_evt_valid <= w_found;
            if (w_found) begin
                r_evt_code <= {2'b00, w_sel_type, w_sel_idx};
                r_evt_cnt  <= r_evt_cnt + 8'd1;
            end
        end
    end

    assign bus.btn_state_o = w_btn_state;
    assign bus.evt_valid_o = r_evt_valid;
    assign bus.evt_code_o  = r_evt_code;
    assign bus.evt_cnt_o   = r_evt_cnt;

endmodule
`default_nettype wire

// File: doc/btn_event_gen.md
# btn_event_gen

Debounces the front-panel buttons and turns each into short-press, long-press and auto-repeat events for the CPU. It sits between the clk27 button synchronizers (`btn_LL`) and the `controls` PIO word. It exposes debounced levels, a last-event code and a wrapping event counter, and the firmware polls the counter the same way it polls `ir_code_cnt`.

## Interface
- NUM_BTN, 2, number of buttons (1..16)
- TICKS_PER_MS, 27000, clk27 cycles per millisecond tick
- DEBOUNCE_MS, 20, consecutive stable ms ticks required to accept a level change
- LONGPRESS_MS, 1000, ms held before LONG event (≤4095)
- REPEAT_MS, 200, ms between REPEAT events after LONG (≤4095)

Ports:
- clk27  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- btn_i  in  NUM_BTN  already-synchronized button inputs, active low (0 = pressed)
- btn_state_o  out  NUM_BTN  debounced level, 1 = pressed
- evt_valid_o  out  1  one-cycle pulse per emitted event
- evt_code_o  out  8  last event: [7:6]=00, [5:4]=type (01 SHORT, 10 LONG, 11 REPEAT), [3:0]=button index
- evt_cnt_o  out  8  event counter, +1 per evt_valid_o, wraps 255→0

## Operation
- Shared prescaler counts 0..TICKS_PER_MS-1. `ms_tick` is high for one cycle when the prescaler is at TICKS_PER_MS-1. All FSM timing advances only on `ms_tick`.
- Per-button FSM states: LOCKOUT, IDLE, PRESS_DB, HELD, RELEASE_DB. Each button also has a `long_flag` bit, a 5-bit debounce counter `db_cnt` and a 12-bit saturating `hold_cnt`.
- LOCKOUT (reset state): a button held through reset is ignored. On a tick, a released input increments `db_cnt` and a pressed input clears it. When `db_cnt` reaches DEBOUNCE_MS → IDLE.
- IDLE: a pressed input → PRESS_DB with `db_cnt`=0. This transition does not wait for a tick.
- PRESS_DB: on a tick, a pressed input increments `db_cnt` and a released input → IDLE. When `db_cnt` reaches DEBOUNCE_MS → HELD with `hold_cnt`=0 and `long_flag`=0.
- HELD: on a tick, increment `hold_cnt`.
  - When `hold_cnt` reaches LONGPRESS_MS with `long_flag`=0: emit LONG, set `long_flag`, clear `hold_cnt`.
  - With `long_flag`=1, when `hold_cnt` reaches REPEAT_MS: emit REPEAT and clear `hold_cnt`.
  - A released input → RELEASE_DB with `db_cnt`=0.
- RELEASE_DB: `hold_cnt` is frozen. On a tick, a released input increments `db_cnt` and a pressed input → HELD with counters unchanged. When `db_cnt` reaches DEBOUNCE_MS → IDLE, and a SHORT event is emitted if `long_flag`=0.
- btn_state_o[i] = 1 in HELD and RELEASE_DB, 0 otherwise.
- Event pending: each button has a pending valid bit and a type. An FSM emission sets them, overwriting any unserved pending event of that button.
- Arbiter: each cycle it serves the lowest-index pending button. It clears that button's pending bit and registers evt_valid_o=1, evt_code_o and evt_cnt_o+1.
- Simultaneous pendings on several buttons are served one per cycle in index order; no event is lost.
- Reset: all FSMs → LOCKOUT, all counters and pending bits 0, prescaler 0. Every output is 0 (btn_state_o, evt_valid_o, evt_code_o, evt_cnt_o).

## Timing
- Debounce acceptance falls between (DEBOUNCE_MS−1)·TICKS_PER_MS and DEBOUNCE_MS·TICKS_PER_MS cycles after the last bounce.
- Let T be the cycle in which `ms_tick` triggers the FSM emission.
  - The pending bit is visible at T+1.
  - With no contention, evt_valid_o and the updated evt_code_o/evt_cnt_o appear at T+2.
  - Each lower-index contender adds 1 cycle.
- btn_state_o changes at T+1 relative to the accepting tick.
- evt_code_o holds its value until the next event. evt_cnt_o changes only together with evt_valid_o.
- Reset asserted mid-press: outputs are 0 the next cycle, and the button must be released and debounced before it is recognised again.

## Configuration
- BTN_REPEAT_EN defined: REPEAT events are generated as described.
- BTN_REPEAT_EN undefined: no repeat logic is built. After LONG, `hold_cnt` stops and the button stays in HELD silently until released. Code type 11 never occurs.

## Test plan
All scenarios use TICKS_PER_MS=4, DEBOUNCE_MS=3, LONGPRESS_MS=10, REPEAT_MS=4 and BTN_REPEAT_EN defined unless stated.
- Reset is released with btn_i=2'b10 (btn0 held). btn_i is then kept at 2'b10 for 100 cycles → no events and btn_state_o=0. Release btn0, then press it cleanly → normal debounce and SHORT on release.
- Press btn0 for 5 ms, then release, both cleanly → btn_state_o[0] rises after ≈3 ms. Exactly one evt_valid_o with code 8'h10, and evt_cnt_o=1.
- Hold btn1 for 20 ms → LONG with code 8'h21 at ≈13 ms, then REPEAT 8'h31 every 4 ms. No SHORT is emitted on release.
- Toggle btn0 every 6 cycles for 40 cycles, then leave it released → btn_state_o stays 0 and no events occur.
- Release btn0 and btn1 so that both SHORTs fire on the same tick → evt_valid_o on two consecutive cycles, codes 8'h10 then 8'h11. Start with evt_cnt_o=255 → it wraps to 0 and then 1.
- With BTN_REPEAT_EN undefined, hold btn0 for 30 ms → exactly one event, LONG 8'h20.
